// File: rtl/uart_rx.sv
// Oversampled UART receiver with mid-bit sampling and a single-word output buffer.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int OSR    = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              osr_tick_i,
  input  logic              rx_i,
`ifdef UART_RX_PARITY_EN
  input  logic              parity_odd_i,
  output logic              parity_err_o,
`endif
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              frame_err_o,
  output logic              overrun_o
);

  localparam int CW = $clog2(OSR);
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OSR - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a low sample
  // S_START  | qualifying the start bit at its midpoint
  // S_DATA   | sampling data bits mid-bit, LSB first
  // S_PARITY | sampling the parity bit (parity builds only)
  // S_STOP   | sampling the stop bit and delivering the word
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              rx_meta_q, rx_meta_d;
  logic              rx_s_q, rx_s_d;
  logic              par_ok;

`ifdef UART_RX_PARITY_EN
  logic par_ok_q, par_ok_d;
  logic parity_err_q, parity_err_d;
  assign par_ok = par_ok_q;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    rx_meta_d   = rx_i;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_d     = par_ok_q;
    parity_err_d = 1'b0;
`endif

    if (valid_q && ready_i) valid_d = 1'b0;

    if (osr_tick_i) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            state_d = rx_s_q ? S_IDLE : S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_FULL) begin
            shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
            cnt_d   = '0;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == CNT_FULL) begin
            par_ok_d = ((^shift_q) ^ rx_s_q) == parity_odd_i;
            state_d  = S_STOP;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == CNT_FULL) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            // Frame error outranks parity error; either one discards the word.
            if (!rx_s_q) begin
              frame_err_d = 1'b1;
            end else if (!par_ok) begin
`ifdef UART_RX_PARITY_EN
              parity_err_d = 1'b1;
`endif
            end else if (!valid_q || ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_ok_q     <= 1'b1;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
`ifdef UART_RX_PARITY_EN
      par_ok_q     <= par_ok_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: OSR=16, DATA_W=8, oversample strobe every 4 clocks.
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  localparam int OSR     = 16;
  localparam int DW      = 8;
  localparam int BIT_CLK = OSR * 4;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic          osr_tick_i = 1'b0;
  logic          rx_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          frame_err_o;
  logic          overrun_o;
`ifdef UART_RX_PARITY_EN
  logic          parity_odd_i;
  logic          parity_err_o;
`endif

  uart_rx #(.OSR(OSR), .DATA_W(DW)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .osr_tick_i  (osr_tick_i),
    .rx_i        (rx_i),
`ifdef UART_RX_PARITY_EN
    .parity_odd_i(parity_odd_i),
    .parity_err_o(parity_err_o),
`endif
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in for baud_gen with div_i=4: one-cycle strobe every fourth clock.
  int div_cnt = 0;
  always @(negedge clk_i) begin
    div_cnt    = (div_cnt == 3) ? 0 : div_cnt + 1;
    osr_tick_i = (div_cnt == 3);
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_hs = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, hold_bad = 0;
  bit hold_chk = 1'b0;
  logic [DW-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    #1;
    if (reset_ni) begin
      if (valid_o && ready_i) begin
        n_hs++;
        if (sb.size() == 0) check("unexpected_valid", {31'b0, valid_o}, 32'd0);
        else check("rx_data", {24'b0, data_o}, {24'b0, sb.pop_front()});
      end
      if (frame_err_o) n_ferr++;
      if (overrun_o) n_ovr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) n_perr++;
`endif
      if (hold_chk && (!valid_o || data_o != 8'h11)) hold_bad++;
    end
  end

  task automatic drive_bit(input logic b, input int clks);
    rx_i = b;
    repeat (clks) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_hi, input logic par_flip);
    @(negedge clk_i);
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < DW; i++) drive_bit(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ parity_odd_i ^ par_flip, BIT_CLK);
`endif
    if (stop_hi) begin
      drive_bit(1'b1, BIT_CLK);
    end else begin
      // Hold low past the stop sample point, then release so no phantom frame follows.
      drive_bit(1'b0, 48);
      drive_bit(1'b1, BIT_CLK - 48);
    end
    drive_bit(1'b1, 2 * BIT_CLK);
  endtask

  int hs0;

  initial begin
    rx_i     = 1'b1;
    ready_i  = 1'b1;
    reset_ni = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_odd_i = 1'b1;
`endif
    repeat (5) @(negedge clk_i);
    #1;
    check("rst_data", {24'b0, data_o}, 32'h0);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_ferr", {31'b0, frame_err_o}, 32'd0);
    check("rst_ovr", {31'b0, overrun_o}, 32'd0);
    @(negedge clk_i) reset_ni = 1'b1;
    repeat (20) @(negedge clk_i);

    hs0 = n_hs;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_handshakes", n_hs - hs0, 1);
    check("a5_ferr", n_ferr, 0);
    check("a5_ovr", n_ovr, 0);
    check("a5_valid_clear", {31'b0, valid_o}, 32'd0);

    hs0 = n_hs;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 4 * BIT_CLK);
    check("false_start_hs", n_hs - hs0, 0);
    check("false_start_ferr", n_ferr, 0);

    hs0 = n_hs;
    send_frame(8'h3C, 1'b0, 1'b0);
    check("stop_low_ferr", n_ferr, 1);
    check("stop_low_hs", n_hs - hs0, 0);
    check("stop_low_valid", {31'b0, valid_o}, 32'd0);
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("after_ferr_hs", n_hs - hs0, 1);
    check("after_ferr_ferr", n_ferr, 1);

    hs0 = n_hs;
    ready_i = 1'b0;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    check("ovr_valid1", {31'b0, valid_o}, 32'd1);
    check("ovr_data1", {24'b0, data_o}, 32'h11);
    hold_chk = 1'b1;
    send_frame(8'h22, 1'b1, 1'b0);
    hold_chk = 1'b0;
    check("ovr_count", n_ovr, 1);
    check("ovr_hold", hold_bad, 0);
    check("ovr_data2", {24'b0, data_o}, 32'h11);
    @(negedge clk_i) ready_i = 1'b1;
    @(negedge clk_i) ready_i = 1'b0;
    #1;
    check("ovr_valid_clear", {31'b0, valid_o}, 32'd0);
    check("ovr_hs", n_hs - hs0, 1);
    ready_i = 1'b1;

    @(negedge clk_i);
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b1, 3 * BIT_CLK);
    reset_ni = 1'b0;
    @(negedge clk_i) reset_ni = 1'b1;
    #1;
    check("mid_rst_data", {24'b0, data_o}, 32'h0);
    check("mid_rst_valid", {31'b0, valid_o}, 32'd0);
    check("mid_rst_ferr", {31'b0, frame_err_o}, 32'd0);
    check("mid_rst_ovr", {31'b0, overrun_o}, 32'd0);
    hs0 = n_hs;
    drive_bit(1'b1, 4 * BIT_CLK);
    check("mid_rst_no_hs", n_hs - hs0, 0);
    check("mid_rst_no_ferr", n_ferr, 1);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("post_rst_hs", n_hs - hs0, 1);

`ifdef UART_RX_PARITY_EN
    hs0 = n_hs;
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_bad_perr", n_perr, 1);
    check("par_bad_hs", n_hs - hs0, 0);
    check("par_bad_valid", {31'b0, valid_o}, 32'd0);
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_good_hs", n_hs - hs0, 1);
    check("par_good_perr", n_perr, 1);
`endif

    check("final_ferr", n_ferr, 1);
    check("final_ovr", n_ovr, 1);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OSR, default 16, oversample ticks per bit; legal range 4..64, even values only.
REQ-002 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-003 clk_i  input  1  single clock; all logic is clocked on its rising edge.
REQ-004 reset_ni  input  1  synchronous, active-low reset.
REQ-005 osr_tick_i  input  1  oversample strobe, one clk_i cycle wide, from baud_gen osr_tick_o.
REQ-006 rx_i  input  1  asynchronous serial line; idle high.
REQ-007 data_o  output  DATA_W  received word, LSB first on the line.
REQ-008 valid_o  output  1  data_o holds an unconsumed word.
REQ-009 ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
REQ-010 frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun_o  output  1  one-cycle pulse: completed word dropped because the buffer was full.

Function
REQ-012 rx_i shall pass through a 2-flop synchronizer with both flops reset to 1; all decisions use the synchronized value rx_s.
REQ-013 The FSM states shall be IDLE, START, DATA, PARITY (macro only), and STOP; the FSM and tick counter shall advance only on cycles with osr_tick_i=1.
REQ-014 IDLE: on a tick with rx_s=0, go to START with tick counter=0.
REQ-015 START: at tick count OSR/2-1, sample rx_s; 1 -> IDLE (false start, no outputs); 0 -> DATA, counter cleared, bit index=0.
REQ-016 DATA: sample rx_s every OSR ticks (mid-bit), shifting LSB first; after DATA_W samples go to PARITY (macro) or STOP.
REQ-017 STOP: sample rx_s after OSR ticks, then return to IDLE on the same tick.
REQ-018 Stop sample 0: pulse frame_err_o for one cycle, discard the word, leave valid_o and data_o unchanged.
REQ-019 Stop sample 1: on the next clk_i edge, load data_o and set valid_o=1 when the buffer is empty or is being accepted in that same cycle.
REQ-020 Stop sample 1 with valid_o=1 and ready_i=0: pulse overrun_o for one cycle, drop the new word, hold data_o.
REQ-021 valid_o shall clear on the edge after valid_o && ready_i unless a new word loads in that same cycle (REQ-019).
REQ-022 data_o shall be stable while valid_o=1; ready_i shall have no effect while valid_o=0.
REQ-023 osr_tick_i=0 for any duration shall freeze the FSM and counters; no timeout.
REQ-024 The tick counter shall be $clog2(OSR) bits wide and the bit index $clog2(DATA_W+1) bits wide; neither shall wrap within a state.

Reset
REQ-025 On a clock edge with reset_ni=0: FSM=IDLE, counters=0, data_o=0, valid_o=0, all error pulses 0, synchronizer flops=1.
REQ-026 A reset mid-frame shall abandon the frame with no pulses; reception resumes on the next start bit after release.

Configuration
REQ-027 Macro UART_RX_PARITY_EN: when defined, add input parity_odd_i (1 = odd, 0 = even) and output parity_err_o, and enable the PARITY state.
REQ-028 With the macro: PARITY samples one bit after OSR ticks; on a mismatch, pulse parity_err_o for one cycle in the stop-sample cycle and discard the word (no valid_o, no overrun_o); frame_err_o takes priority if both occur.
REQ-029 Without the macro: no parity ports and no PARITY state; frames are 1 start, DATA_W data, 1 stop.

Verification
REQ-030 The bench shall use OSR=16, DATA_W=8, and osr_tick_i from baud_gen with div_i=4.
REQ-031 Frame 0xA5 with ready_i=1 -> exactly one valid_o cycle with data_o=0xA5, and no error pulses.
REQ-032 rx_i low for 4 ticks, then high -> no valid_o, no frame_err_o, and the FSM returns to IDLE.
REQ-033 Frame 0x3C with the stop bit forced low -> frame_err_o pulses once, valid_o stays 0, and the next frame 0x3C is received correctly.
REQ-034 Frames 0x11 then 0x22 with ready_i=0 -> data_o=0x11 and valid_o=1 throughout, overrun_o pulses once at the 0x22 stop sample; after ready_i=1 for one cycle, valid_o=0.
REQ-035 Assert reset_ni=0 for one cycle during the data bits of frame 0xFF -> all outputs are 0; the following frame 0x5A gives data_o=0x5A.
REQ-036 With UART_RX_PARITY_EN and parity_odd_i=1, frame 0x07 with a wrong parity bit -> parity_err_o pulses once and valid_o stays 0; with the correct bit, data_o=0x07.
